// File: rtl/irrigation_pkg.sv
// Shared types, 7-segment patterns and round-robin pick helper for the irrigation scheduler.
package irrigation_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        GAP  = 2'd2
    } state_t;

    // Active-low segments, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_A     = 7'b1111110;
    localparam logic [6:0] SEG_B     = 7'b1111101;
    localparam logic [6:0] SEG_C     = 7'b1111011;
    localparam logic [6:0] SEG_D     = 7'b1110111;
    localparam logic [6:0] SEG_E     = 7'b1101111;
    localparam logic [6:0] SEG_F     = 7'b1011111;
    localparam logic [6:0] SEG_G     = 7'b0111111;
    localparam logic [6:0] SEG_MID   = SEG_G;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    function automatic logic [2:0] rr_pick(
        input logic [7:0] pend,
        input logic [2:0] ptr,
        input int         n
    );
        logic [2:0] pick;
        logic       found;
        int         idx;
        pick  = '0;
        found = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            idx = (int'(ptr) + i) % n;
            if (i <= n && !found && pend[3'(idx)]) begin
                pick  = 3'(idx);
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    function automatic logic [6:0] anim_seg(input logic [2:0] idx);
        logic [6:0] seg;
        case (idx)
            3'd0:    seg = SEG_A;
            3'd1:    seg = SEG_B;
            3'd2:    seg = SEG_C;
            3'd3:    seg = SEG_D;
            3'd4:    seg = SEG_E;
            3'd5:    seg = SEG_F;
            default: seg = SEG_A;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/sec_prescaler.sv
// Free-running cycle counter that pulses tick once per CYCLES_PER_SEC cycles.
module sec_prescaler #(
    parameter int CYCLES_PER_SEC = 50000000
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    output logic tick
);

    localparam int CW = (CYCLES_PER_SEC > 1) ? $clog2(CYCLES_PER_SEC) : 1;

    logic [CW-1:0] cnt;

    assign tick = (cnt == CW'(CYCLES_PER_SEC - 1));

    always_ff @(posedge clk) begin
        if (reset || clr || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/irrigation_zone_scheduler.sv
// Round-robin single-pump irrigation scheduler with short/long runs and dead-time gaps.
// Optional sprinkler animation on hex_anim is enabled by defining SPRINKLER_ANIM_EN.
module irrigation_zone_scheduler
    import irrigation_pkg::*;
#(
    parameter int NUM_ZONES      = 4,
    parameter int CYCLES_PER_SEC = 50000000,
    parameter int SHORT_SEC      = 3,
    parameter int LONG_SEC       = 6,
    parameter int GAP_SEC        = 1
) (
    input  logic                         CLOCK_50,
    input  logic                         reset,
    input  logic [NUM_ZONES-1:0]         req_short,
    input  logic [NUM_ZONES-1:0]         req_long,
    input  logic                         cancel,
    output logic [NUM_ZONES-1:0]         valve_en,
    output logic                         pump_en,
    output logic [$clog2(NUM_ZONES)-1:0] active_zone,
    output logic [NUM_ZONES-1:0]         pending,
    output logic                         led_run,
    output logic                         led_idle,
    output logic [6:0]                   hex_anim
);

    localparam int ZW   = $clog2(NUM_ZONES);
    localparam int MAX1 = (LONG_SEC > SHORT_SEC) ? LONG_SEC : SHORT_SEC;
    localparam int MAXS = (MAX1 > GAP_SEC) ? MAX1 : GAP_SEC;
    localparam int SW   = $clog2(MAXS + 1);

    state_t                 state_q, state_d;
    logic [NUM_ZONES-1:0]   pending_q, pending_d;
    logic [NUM_ZONES-1:0]   long_q, long_d;
    logic [ZW-1:0]          rr_q, rr_d;
    logic [ZW-1:0]          zone_q, zone_d;
    logic [SW-1:0]          sec_q, sec_d;
    logic                   run_long_q, run_long_d;
    logic [ZW-1:0]          pick;
    logic [SW-1:0]          run_last;
    logic                   tick;
    logic                   clr;

    assign pick     = ZW'(rr_pick(8'(pending_q), 3'(rr_q), NUM_ZONES));
    assign run_last = run_long_q ? SW'(LONG_SEC - 1) : SW'(SHORT_SEC - 1);
    assign clr      = (state_q == IDLE) || (state_d != state_q);

    sec_prescaler #(
        .CYCLES_PER_SEC(CYCLES_PER_SEC)
    ) u_prescaler (
        .clk  (CLOCK_50),
        .reset(reset),
        .clr  (clr),
        .tick (tick)
    );

    always_comb begin
        state_d    = state_q;
        pending_d  = pending_q;
        long_d     = long_q;
        rr_d       = rr_q;
        zone_d     = zone_q;
        sec_d      = sec_q;
        run_long_d = run_long_q;
        unique case (state_q)
            IDLE: begin
                if (|pending_q) begin
                    state_d         = RUN;
                    zone_d          = pick;
                    rr_d            = pick;
                    run_long_d      = long_q[pick];
                    pending_d[pick] = 1'b0;
                    long_d[pick]    = 1'b0;
                    sec_d           = '0;
                end
            end
            RUN: begin
                if (tick) begin
                    if (sec_q == run_last) begin
                        state_d = GAP;
                        sec_d   = '0;
                    end else begin
                        sec_d = sec_q + SW'(1);
                    end
                end
            end
            GAP: begin
                if (tick) begin
                    if (sec_q == SW'(GAP_SEC - 1)) begin
                        state_d = IDLE;
                        sec_d   = '0;
                    end else begin
                        sec_d = sec_q + SW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        // New requests latch after the grant clear, so the running zone can re-queue
        pending_d = pending_d | req_short | req_long;
        long_d    = long_d | req_long;
        if (cancel) begin
            state_d   = IDLE;
            pending_d = '0;
            long_d    = '0;
            sec_d     = '0;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q    <= IDLE;
            pending_q  <= '0;
            long_q     <= '0;
            rr_q       <= ZW'(NUM_ZONES - 1);
            zone_q     <= '0;
            sec_q      <= '0;
            run_long_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            long_q     <= long_d;
            rr_q       <= rr_d;
            zone_q     <= zone_d;
            sec_q      <= sec_d;
            run_long_q <= run_long_d;
        end
    end

    assign pump_en     = (state_q == RUN);
    assign valve_en    = pump_en ? (NUM_ZONES'(1) << zone_q) : '0;
    assign active_zone = pump_en ? zone_q : '0;
    assign pending     = pending_q;
    assign led_run     = pump_en;
    assign led_idle    = (state_q == IDLE);

`ifdef SPRINKLER_ANIM_EN
    logic [2:0] anim_q;

    always_ff @(posedge CLOCK_50) begin
        if (reset || state_q == IDLE) begin
            anim_q <= '0;
        end else if (state_q == RUN && tick) begin
            anim_q <= (anim_q == 3'd5) ? 3'd0 : anim_q + 3'd1;
        end
    end

    assign hex_anim = pump_en ? anim_seg(anim_q) : SEG_MID;
`else
    assign hex_anim = SEG_BLANK;
`endif

endmodule
